// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered 8-bit alu between two requesters.
// Defining ALU_ARB_ERR_EN blanks illegal opcodes and returns them with rsp_err set.
module alu_arbiter #(
  parameter int ALU_LAT = 2
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [3:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req1_op,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_ctr,
  input  logic [7:0] alu_o
);

  localparam int LAST = ALU_LAT - 1;

  logic               prio;
  logic               grant_any;
  logic               grant_id;
  logic [7:0]         sel_a;
  logic [7:0]         sel_b;
  logic [3:0]         sel_op;
  logic               issue;
  logic               rsp_vld;
  logic [ALU_LAT-1:0] pipe_vld;
  logic [ALU_LAT-1:0] pipe_id;

  // Grants are withheld during reset so nothing can enter a pipe that is being cleared.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_id  = prio;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any && grant_id;

  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_b  = grant_id ? req1_b  : req0_b;
  assign sel_op = grant_id ? req1_op : req0_op;

`ifdef ALU_ARB_ERR_EN
  logic               sel_illegal;
  logic [ALU_LAT-1:0] pipe_err;

  assign sel_illegal = !((sel_op == 4'b0000) || (sel_op == 4'b0001) || sel_op[3]);
  assign issue       = grant_any && !sel_illegal;

  always_ff @(posedge ck) begin
    if (rst) begin
      pipe_err <= '0;
    end else begin
      pipe_err[0] <= grant_any && sel_illegal;
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe_err[i] <= pipe_err[i-1];
      end
    end
  end
`else
  assign issue = grant_any;
`endif

  assign alu_a   = issue ? sel_a  : 8'h00;
  assign alu_b   = issue ? sel_b  : 8'h00;
  assign alu_ctr = issue ? sel_op : 4'b0000;

  always_ff @(posedge ck) begin
    if (rst) begin
      prio     <= 1'b0;
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      pipe_vld[0] <= grant_any;
      pipe_id[0]  <= grant_id;
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
      if (grant_any) begin
        prio <= !grant_id;
      end
    end
  end

  // A reset cycle drops the op sitting in the last stage as well.
  assign rsp_vld    = pipe_vld[LAST] && !rst;
  assign rsp0_valid = rsp_vld && !pipe_id[LAST];
  assign rsp1_valid = rsp_vld && pipe_id[LAST];

`ifdef ALU_ARB_ERR_EN
  assign rsp_err  = rsp_vld && pipe_err[LAST];
  assign rsp_data = rsp_err ? 8'h00 : alu_o;
`else
  assign rsp_err  = 1'b0;
  assign rsp_data = alu_o;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: registered alu model, directed scenarios, then random traffic
// checked cycle by cycle against a slot-level reference model.
module tb_alu_arbiter;

  logic       ck = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_op, req1_op;
  logic       rsp0_valid, rsp1_valid, rsp_err;
  logic [7:0] rsp_data;
  logic [7:0] alu_a, alu_b, alu_o;
  logic [3:0] alu_ctr;

  int checks = 0;
  int failures = 0;

  always #5 ck = ~ck;

  alu_arbiter dut (
    .ck(ck), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_o(alu_o)
  );

  function automatic bit legal(input logic [3:0] op);
    return (op == 4'b0000) || (op == 4'b0001) || op[3];
  endfunction

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b1000: return {7'd0, (a != 8'h00) && (b != 8'h00)};
      4'b1001: return {7'd0, (a != 8'h00) || (b != 8'h00)};
      4'b1010: return a ^ b;
      4'b1011: return ~a;
      4'b1100: return a >> 1;
      4'b1101: return a << 1;
      4'b1110: return {a[7], a[7:1]};
      4'b1111: return {a[6:0], a[7]};
      default: return 8'h00;
    endcase
  endfunction

  // External alu: inputs registered, output registered, O held on illegal opcodes.
  logic [7:0] ar = 8'h00, br = 8'h00, orr = 8'h00;
  logic [3:0] cr = 4'b0000;
  always @(posedge ck) begin
    ar <= alu_a;
    br <= alu_b;
    cr <= alu_ctr;
    if (legal(cr)) orr <= alu_f(ar, br, cr);
  end
  assign alu_o = orr;

  // Reference: per-slot issue decisions and a 2-deep queue of expected responses.
  bit         prio_m = 1'b0;
  bit   [1:0] pv = 2'b00, pid = 2'b00, perr = 2'b00;
  logic [7:0] pdata [2];
  logic [7:0] res_prev = 8'h00;

  logic       obs_r0, obs_r1, obs_v0, obs_v1, obs_err;
  logic [7:0] obs_data;
  int         grant_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int g;
    logic [7:0] sa, sb, sres;
    logic [3:0] sc;
    bit ill, ev0, ev1;
    #1;
    g = -1;
    if (!rst) begin
      if (req0_valid && req1_valid) g = prio_m ? 1 : 0;
      else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
    end
    sa = 8'h00; sb = 8'h00; sc = 4'b0000;
    if (g == 0) begin sa = req0_a; sb = req0_b; sc = req0_op; end
    if (g == 1) begin sa = req1_a; sb = req1_b; sc = req1_op; end
    ill = (g >= 0) && !legal(sc);
`ifdef ALU_ARB_ERR_EN
    if (ill) begin sa = 8'h00; sb = 8'h00; sc = 4'b0000; end
`else
    ill = 1'b0;
`endif
    sres = legal(sc) ? alu_f(sa, sb, sc) : res_prev;
    ev0 = !rst && pv[1] && (pid[1] == 1'b0);
    ev1 = !rst && pv[1] && (pid[1] == 1'b1);

    obs_r0 = req0_ready; obs_r1 = req1_ready;
    obs_v0 = rsp0_valid; obs_v1 = rsp1_valid;
    obs_err = rsp_err; obs_data = rsp_data;
    if (req0_ready) grant_log.push_back(0);
    if (req1_ready) grant_log.push_back(1);

    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    chk("alu_a", 32'(alu_a), 32'(sa));
    chk("alu_b", 32'(alu_b), 32'(sb));
    chk("alu_ctr", 32'(alu_ctr), 32'(sc));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
    chk("rsp_err", 32'(rsp_err), 32'((ev0 || ev1) && perr[1]));
    if (ev0 || ev1) chk("rsp_data", 32'(rsp_data), 32'(pdata[1]));

    res_prev = sres;
    if (rst) begin
      pv = 2'b00;
      prio_m = 1'b0;
    end else begin
      pv[1] = pv[0]; pid[1] = pid[0]; perr[1] = perr[0]; pdata[1] = pdata[0];
      pv[0] = (g >= 0);
      pid[0] = (g == 1);
      perr[0] = ill;
      pdata[0] = ill ? 8'h00 : sres;
      if (g >= 0) prio_m = (g == 0);
    end
    @(negedge ck);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic single(input int who, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op);
    if (who == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
    tick();
    chk("single_grant", 32'(who == 0 ? obs_r0 : obs_r1), 32'd1);
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00; req0_op = 4'b0000;
    req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 4'b0000;
    @(negedge ck);
    tick();
    tick();
    chk("reset_ready0", 32'(obs_r0), 32'd0);
    chk("reset_rsp0", 32'(obs_v0), 32'd0);
    rst = 1'b0;

    // Single op from requester 0.
    single(0, 8'h05, 8'h03, 4'b0000);
    chk("t1_rsp0", 32'(obs_v0), 32'd1);
    chk("t1_rsp1", 32'(obs_v1), 32'd0);
    chk("t1_data", 32'(obs_data), 32'h08);

    // Wrap, shifts and rotate.
    single(0, 8'hFF, 8'h01, 4'b0000);
    chk("t3_wrap", 32'(obs_data), 32'h00);
    single(0, 8'h81, 8'h00, 4'b1110);
    chk("t3_asr", 32'(obs_data), 32'hC0);
    single(0, 8'h81, 8'h00, 4'b1111);
    chk("t3_rol", 32'(obs_data), 32'h03);
    single(0, 8'h81, 8'h00, 4'b1101);
    chk("t3_shl", 32'(obs_data), 32'h02);

    // Contention: three ops each, grants must alternate from requester 0.
    reset_pulse();
    grant_log.delete();
    begin
      int n0 = 3, n1 = 3;
      req0_a = 8'h10; req0_b = 8'h01; req0_op = 4'b0001;
      req1_a = 8'hF0; req1_b = 8'h5A; req1_op = 4'b1011;
      for (int k = 0; k < 10 && (n0 > 0 || n1 > 0); k++) begin
        req0_valid = (n0 > 0); req1_valid = (n1 > 0);
        tick();
        if (obs_r0) n0--;
        if (obs_r1) n1--;
      end
      chk("t2_done", 32'(n0 + n1), 32'd0);
    end
    idle_inputs();
    tick();
    chk("t2_last_data", 32'(obs_data), 32'h0F);
    tick();
    chk("t2_last_rsp1", 32'(obs_v1), 32'd1);
    chk("t2_grant_count", 32'(grant_log.size()), 32'd6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      chk("t2_grant_order", 32'(grant_log[k]), 32'(k % 2));

    // Illegal opcode right after a legal one from requester 1.
    req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44; req1_op = 4'b0000;
    tick();
    req1_a = 8'h12; req1_b = 8'h34; req1_op = 4'b0100;
    tick();
    idle_inputs();
    tick();
    chk("t5_prev_data", 32'(obs_data), 32'h77);
    tick();
    chk("t5_rsp1", 32'(obs_v1), 32'd1);
`ifdef ALU_ARB_ERR_EN
    chk("t5_err", 32'(obs_err), 32'd1);
    chk("t5_data", 32'(obs_data), 32'h00);
`else
    chk("t5_err", 32'(obs_err), 32'd0);
    chk("t5_data", 32'(obs_data), 32'h77);
`endif

    // Reset mid-flight drops both in-flight ops and returns prio to requester 0.
    reset_pulse();
    req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h02; req1_op = 4'b0000;
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h04; req0_op = 4'b0000;
    tick();
    rst = 1'b1; req1_valid = 1'b1;
    tick();
    chk("t4_rst_ready0", 32'(obs_r0), 32'd0);
    chk("t4_rst_ready1", 32'(obs_r1), 32'd0);
    chk("t4_rst_rsp", 32'({obs_v0, obs_v1}), 32'd0);
    rst = 1'b0; idle_inputs();
    tick();
    chk("t4_c4_rsp", 32'({obs_v0, obs_v1}), 32'd0);
    tick();
    chk("t4_c5_rsp", 32'({obs_v0, obs_v1}), 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'h20; req0_b = 8'h22; req0_op = 4'b0000;
    tick();
    chk("t4_prio_ready0", 32'(obs_r0), 32'd1);
    idle_inputs();
    tick();
    tick();
    chk("t4_after_rsp0", 32'(obs_v0), 32'd1);
    chk("t4_after_data", 32'(obs_data), 32'h42);

    // Priority holds across idle cycles.
    reset_pulse();
    req1_valid = 1'b1; req1_op = 4'b1010;
    tick();
    tick();
    idle_inputs();
    tick();
    chk("t6_idle_ready", 32'({obs_r0, obs_r1}), 32'd0);
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1; req0_op = 4'b1001;
    tick();
    chk("t6_ready0", 32'(obs_r0), 32'd1);
    chk("t6_ready1", 32'(obs_r1), 32'd0);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      rst        = ($urandom_range(0, 39) == 0);
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a  = 8'($urandom); req0_b = 8'($urandom); req0_op = 4'($urandom_range(0, 15));
      req1_a  = 8'($urandom); req1_b = 8'($urandom); req1_op = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0; idle_inputs();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
